multicycle_control: RTL and testbench

Finite-state control unit for the multicycle MIPS datapath, replacing the single-cycle combinational `Control` decode. It sequences one instruction over 3–5+ cycles using a single shared memory port for instructions and data. It drives the existing `ALUControl` through `ALUOp`, the PC/IR/MDR enables, and the register-file write path. Supported instructions: add, sub, and, or, nor, addi, ori, lui, lw, sw, beq, bne, j, jal, jr.

---
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
// Finite-state control unit for the multicycle MIPS datapath. Sequences one
// instruction over several cycles through a single shared memory port and
// drives ALUControl (via ALUOp), the PC/IR enables and the register-file
// write path. Moore decode, except for the few outputs that are qualified by
// MemReady or Zero.

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegDst,
  output logic       JalReg,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    WB_R      = 4'd8,
    EXEC_I    = 4'd9,
    WB_I      = 4'd10,
    LUI_WB    = 4'd11,
    BRANCH    = 4'd12,
    JUMP      = 4'd13,
    JAL       = 4'd14,
    JR        = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_R   = 3'b111;

  state_t state, next_state;

  // Where an instruction ends: fetch the next one if Run is held, else park
  state_t boundary_state;
  assign boundary_state = Run ? FETCH : IDLE;

  assign State = state;

  // State register; the asynchronous reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: opcode dispatch in DECODE, memory waits, boundaries
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      next_state = Run ? FETCH : IDLE;
      FETCH:     next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_RTYPE:        next_state = (Funct == FN_JR) ? JR : EXEC_R;
          OP_ADDI, OP_ORI: next_state = EXEC_I;
          OP_LUI:          next_state = LUI_WB;
          OP_LW, OP_SW:    next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:  next_state = BRANCH;
          OP_J:            next_state = JUMP;
          OP_JAL:          next_state = JAL;
          default:         next_state = boundary_state;
        endcase
      end
      MEM_ADDR:  next_state = (Op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next_state = MemReady ? MEM_WB : MEM_READ;
      MEM_WRITE: next_state = MemReady ? boundary_state : MEM_WRITE;
      EXEC_R:    next_state = WB_R;
      EXEC_I:    next_state = WB_I;
      MEM_WB, WB_R, WB_I, LUI_WB, BRANCH, JUMP, JAL, JR:
                 next_state = boundary_state;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode: pure function of state except the MemReady/Zero qualifiers
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSource  = 2'd0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'd0;
    ALUOp     = ALU_ADD;
    RegDst    = 1'b0;
    JalReg    = 1'b0;
    MemtoReg  = 2'd0;
    RegWrite  = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;
    unique case (state)
      IDLE: ;
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'd1;
        ALUOp    = ALU_ADD;
        PCSource = 2'd0;
        IRWrite  = MemReady;
        PCWrite  = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        ALUOp   = ALU_ADD;
        case (Op)
          OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
          OP_BEQ, OP_BNE, OP_J, OP_JAL: ;
          default: begin
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp   = ALU_ADD;
      end
      MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        MemtoReg  = 2'd1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEM_WRITE: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_R;
      end
      WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp   = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      WB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      LUI_WB: begin
        MemtoReg  = 2'd3;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSource  = 2'd1;
        PCWrite   = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
        InstrDone = 1'b1;
      end
      JUMP: begin
        PCSource  = 2'd2;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      JAL: begin
        PCSource  = 2'd2;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
        JalReg    = 1'b1;
        MemtoReg  = 2'd2;
        InstrDone = 1'b1;
      end
      JR: begin
        PCSource  = 2'd3;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for the multicycle control FSM: walks reset, each
// instruction class, memory waits, branch conditions, illegal opcodes,
// mid-access reset and Run release, comparing state and every control
// output against hand-computed expectations.

module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic       Run;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       RegDst, JalReg;
  logic [1:0] MemtoReg;
  logic       RegWrite, InstrDone, IllegalOp;
  logic [3:0] State;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       jal_reg;
    logic [1:0] memto_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  ctl_t exp_c;
  ctl_t act_c;
  int   checks;
  int   passes;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Run(Run), .Op(Op), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .JalReg(JalReg), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
    .State(State)
  );

  assign act_c = '{IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
                   ALUSrcA, ALUSrcB, ALUOp, RegDst, JalReg, MemtoReg,
                   RegWrite, InstrDone, IllegalOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then leave a margin before inputs change
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Compare state and all control outputs against the expectation
  task automatic checkOutput(input string tag, input logic [3:0] exp_state);
    #1;
    checks++;
    assert ({State, act_c} === {exp_state, exp_c}) passes++;
    else begin
      $display("[TB] FAIL %s: observed state=%0d ctl=%h, expected state=%0d ctl=%h",
               tag, State, act_c, exp_state, exp_c);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // Expected FETCH outputs, write enables depending on MemReady
  task automatic expFetch(input logic ready);
    exp_c = '0;
    exp_c.mem_read  = 1'b1;
    exp_c.alu_src_b = 2'd1;
    exp_c.ir_write  = ready;
    exp_c.pc_write  = ready;
  endtask

  // Expected DECODE outputs for a legal opcode
  task automatic expDecode();
    exp_c = '0;
    exp_c.alu_src_b = 2'd3;
  endtask

  // Directed sequence covering every state and the timing corner cases
  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b0; Run = 1'b1; MemReady = 1'b1;
    Op = 6'h00; Funct = 6'h20; Zero = 1'b0;
    exp_c = '0;

    step(); step();
    exp_c = '0;
    checkOutput("reset_idle", 4'd0);
    reset = 1'b1;

    // add: 1, 2, 7, 8
    step(); expFetch(1'b1);  checkOutput("add_fetch", 4'd1);
    step(); expDecode();     checkOutput("add_decode", 4'd2);
    step(); exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_op = 3'b111;
    checkOutput("add_exec", 4'd7);
    step(); exp_c = '0; exp_c.reg_dst = 1'b1; exp_c.reg_write = 1'b1;
    exp_c.instr_done = 1'b1;
    checkOutput("add_wb", 4'd8);

    // lw with a fetch wait and two MEM_READ wait cycles
    step(); MemReady = 1'b0; expFetch(1'b0); checkOutput("lw_fetch_wait", 4'd1);
    step(); MemReady = 1'b1; Op = 6'h23; expFetch(1'b1);
    checkOutput("lw_fetch", 4'd1);
    step(); expDecode(); checkOutput("lw_decode", 4'd2);
    step(); exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_src_b = 2'd2;
    checkOutput("lw_addr", 4'd3);
    step(); MemReady = 1'b0;
    exp_c = '0; exp_c.iord = 1'b1; exp_c.mem_read = 1'b1;
    checkOutput("lw_read_w1", 4'd4);
    step(); checkOutput("lw_read_w2", 4'd4);
    step(); MemReady = 1'b1; checkOutput("lw_read_go", 4'd4);
    step(); exp_c = '0; exp_c.memto_reg = 2'd1; exp_c.reg_write = 1'b1;
    exp_c.instr_done = 1'b1;
    checkOutput("lw_wb", 4'd5);

    // beq, both Zero values
    step(); Op = 6'h04; Zero = 1'b1;
    step(); expDecode(); checkOutput("beq_decode", 4'd2);
    step(); exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_op = 3'b001;
    exp_c.pc_source = 2'd1; exp_c.instr_done = 1'b1; exp_c.pc_write = 1'b1;
    checkOutput("beq_taken", 4'd12);
    Zero = 1'b0; exp_c.pc_write = 1'b0;
    checkOutput("beq_not_taken", 4'd12);

    // bne, both Zero values
    step(); Op = 6'h05;
    step();
    step(); exp_c.pc_write = 1'b1; checkOutput("bne_taken", 4'd12);
    Zero = 1'b1; exp_c.pc_write = 1'b0;
    checkOutput("bne_not_taken", 4'd12);

    // jal
    step(); Op = 6'h03;
    step();
    step(); exp_c = '0; exp_c.pc_source = 2'd2; exp_c.pc_write = 1'b1;
    exp_c.reg_write = 1'b1; exp_c.jal_reg = 1'b1; exp_c.memto_reg = 2'd2;
    exp_c.instr_done = 1'b1;
    checkOutput("jal", 4'd14);

    // jr
    step(); Op = 6'h00; Funct = 6'h08;
    step();
    step(); exp_c = '0; exp_c.pc_source = 2'd3; exp_c.pc_write = 1'b1;
    exp_c.instr_done = 1'b1;
    checkOutput("jr", 4'd15);

    // illegal opcode: pulse in DECODE, then straight back to FETCH
    step(); Op = 6'h3F;
    step(); expDecode(); exp_c.illegal_op = 1'b1; exp_c.instr_done = 1'b1;
    checkOutput("illegal_decode", 4'd2);
    step(); Op = 6'h2B; expFetch(1'b1); checkOutput("illegal_next", 4'd1);

    // sw with one wait cycle in MEM_WRITE
    step();
    step(); exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_src_b = 2'd2;
    checkOutput("sw_addr", 4'd3);
    step(); MemReady = 1'b0;
    exp_c = '0; exp_c.iord = 1'b1; exp_c.mem_write = 1'b1;
    checkOutput("sw_write_wait", 4'd6);
    MemReady = 1'b1; exp_c.instr_done = 1'b1;
    checkOutput("sw_write_done", 4'd6);

    // ori
    step(); Op = 6'h0D;
    step();
    step(); exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_src_b = 2'd2;
    exp_c.alu_op = 3'b010;
    checkOutput("ori_exec", 4'd9);
    step(); exp_c = '0; exp_c.reg_write = 1'b1; exp_c.instr_done = 1'b1;
    checkOutput("ori_wb", 4'd10);

    // lui
    step(); Op = 6'h0F;
    step();
    step(); exp_c = '0; exp_c.memto_reg = 2'd3; exp_c.reg_write = 1'b1;
    exp_c.instr_done = 1'b1;
    checkOutput("lui_wb", 4'd11);

    // reset asserted mid MEM_READ forces IDLE without a clock edge
    step(); Op = 6'h23;
    step();
    step();
    step(); MemReady = 1'b0;
    exp_c = '0; exp_c.iord = 1'b1; exp_c.mem_read = 1'b1;
    checkOutput("rst_pre_read", 4'd4);
    reset = 1'b0;
    exp_c = '0;
    checkOutput("rst_mid_access", 4'd0);
    step(); reset = 1'b1; MemReady = 1'b1; Op = 6'h00; Funct = 6'h20;

    // Run dropped mid-instruction: instruction completes, then IDLE
    step(); expFetch(1'b1); checkOutput("run_fetch", 4'd1);
    step();
    step(); Run = 1'b0;
    exp_c = '0; exp_c.alu_src_a = 1'b1; exp_c.alu_op = 3'b111;
    checkOutput("run_drop_exec", 4'd7);
    step(); exp_c = '0; exp_c.reg_dst = 1'b1; exp_c.reg_write = 1'b1;
    exp_c.instr_done = 1'b1;
    checkOutput("run_drop_wb", 4'd8);
    step(); exp_c = '0; checkOutput("run_drop_idle", 4'd0);
    step(); checkOutput("run_idle_hold", 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
